conv3x3_stream_engine: RTL

Parametrised streaming 3×3 convolution engine, the successor to the fixed 4-wide, 2-channel convolution controller. It accepts a raster-scan, multi-channel pixel stream with a valid/ready handshake and forms 3×3 windows through per-channel line buffers. It multiply-accumulates across all channels and emits one valid-only (no padding, stride 1) output pixel per window under output backpressure. It sits between the ifmap DMA/stream source and the ofmap writeback in the accelerator datapath.

---
 rtl/conv_pkg.sv | 15 +
 rtl/linebuf3x3_param.sv | 47 ++++
 rtl/conv3x3_stream_engine.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 streaming convolution engine.
//   state_e    : frame-level FSM states
//   TAPS       : taps per 3x3 kernel
//   acc_width(): accumulator width needed for CH*9 signed DW x DW products
package conv_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  localparam int unsigned TAPS = 9;

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned ch);
    return 2 * dw + $clog2(TAPS * ch);
  endfunction

endpackage

// File: rtl/linebuf3x3_param.sv
// One channel of line buffering: two IMG_W-deep row delay lines feeding a 3x3 shift window.
// The window registers are the first pipeline stage of the engine.
//   clk : clock
//   en  : shift one pixel in (line buffers and window frozen when low)
//   din : incoming pixel
//   win : 3x3 window, tap k (row-major, k=0 top-left) at [k*DW +: DW]
module linebuf3x3_param
  import conv_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned IMG_W = 6
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [DW-1:0]        din,
  output logic [TAPS*DW-1:0]   win
);

  // row1_q tail = same column one row up, row2_q tail = same column two rows up.
  // Contents are don't-care after reset, so no reset is applied.
  logic [DW-1:0] row1_q [IMG_W];
  logic [DW-1:0] row2_q [IMG_W];
  logic [DW-1:0] win_q  [TAPS];

  always_ff @(posedge clk) begin
    if (en) begin
      row1_q[0] <= din;
      row2_q[0] <= row1_q[IMG_W-1];
      for (int i = 1; i < IMG_W; i++) begin
        row1_q[i] <= row1_q[i-1];
        row2_q[i] <= row2_q[i-1];
      end
      for (int r = 0; r < 3; r++) begin
        win_q[r*3]   <= win_q[r*3+1];
        win_q[r*3+1] <= win_q[r*3+2];
      end
      win_q[2] <= row2_q[IMG_W-1];
      win_q[5] <= row1_q[IMG_W-1];
      win_q[8] <= din;
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_win
    assign win[k*DW +: DW] = win_q[k];
  end

endmodule

// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 valid-only convolution over a CH-channel raster pixel stream.
// Stage 1 is the per-channel window register (in linebuf3x3_param), stage 2 is the
// multiply-accumulate / shift / saturate feeding the dout register.
//   start                 : begin a frame (IDLE only)
//   din/din_valid/din_ready : pixel stream, channel c at [c*DW +: DW]
//   weight                : kernels, channel c tap k at [(c*9+k)*DW +: DW]
//   dout/dout_valid/dout_ready : output pixel stream
//   busy, done            : frame status; done pulses once per frame
// Build option: define CONV3X3_RELU_EN to clamp negative results to zero.
module conv3x3_stream_engine
  import conv_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned IMG_W = 6,
  parameter int unsigned IMG_H = 6,
  parameter int unsigned CH    = 2,
  parameter int unsigned SHIFT = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CH*DW-1:0]       din,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic [CH*TAPS*DW-1:0]  weight,
  output logic [DW-1:0]          dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned ACC_W = acc_width(DW, CH);
  localparam int unsigned CW    = $clog2(IMG_W);
  localparam int unsigned RW    = $clog2(IMG_H);
  localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);
  localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  state_e state_q, state_d;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          s1_valid_q;
  logic [DW-1:0] dout_q;
  logic          dout_valid_q;

  logic adv, accept, last_pix, win_ok;
  logic [CH*TAPS*DW-1:0] win;
  logic [DW-1:0] res;

  // A stall exists only while a result is held and not taken; it freezes everything.
  assign adv       = !(dout_valid_q && !dout_ready);
  assign din_ready = (state_q == RUN) && adv;
  assign accept    = din_valid && din_ready;
  assign last_pix  = (col_q == ColLast) && (row_q == RowLast);
  assign win_ok    = (row_q >= RW'(2)) && (col_q >= CW'(2));

  for (genvar c = 0; c < CH; c++) begin : g_ch
    linebuf3x3_param #(
      .DW    (DW),
      .IMG_W (IMG_W)
    ) u_linebuf (
      .clk (clk),
      .en  (accept),
      .din (din[c*DW +: DW]),
      .win (win[c*TAPS*DW +: TAPS*DW])
    );
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN:   if (accept && last_pix) state_d = DRAIN;
      DRAIN: begin
        if (!s1_valid_q && !dout_valid_q) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (start) begin
          col_q <= '0;
          row_q <= '0;
        end
        s1_valid_q <= 1'b0;
      end else begin
        if (accept) begin
          if (col_q == ColLast) begin
            col_q <= '0;
            row_q <= row_q + RW'(1);
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
        if (adv) s1_valid_q <= accept && win_ok;
      end
    end
  end

  // Stage 2: signed MAC over all channels and taps, then shift and saturate.
  logic signed [DW-1:0]    px, wt;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] acc, shifted;
  logic [DW-1:0]           sat;

  always_comb begin
    acc  = '0;
    px   = '0;
    wt   = '0;
    prod = '0;
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < TAPS; k++) begin
        px   = win[(c*TAPS+k)*DW +: DW];
        wt   = weight[(c*TAPS+k)*DW +: DW];
        prod = px * wt;
        acc  = acc + ACC_W'(prod);
      end
    end
    shifted = acc >>> SHIFT;
    if (shifted > SatMax)      sat = SatMax[DW-1:0];
    else if (shifted < SatMin) sat = SatMin[DW-1:0];
    else                       sat = shifted[DW-1:0];
`ifdef CONV3X3_RELU_EN
    res = sat[DW-1] ? '0 : sat;
`else
    res = sat;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else if (adv) begin
      if (s1_valid_q) dout_q <= res;
      dout_valid_q <= s1_valid_q;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q != IDLE);

endmodule
